// File: rtl/bsg_fifo_rolly_retx_ctrl.sv
// bsg_fifo_rolly_retx_ctrl
// Go-back-N style retransmit controller sitting on the read side of a rolly
// FIFO. Entries are streamed to a valid/ready link and kept in the FIFO until
// released by in-order responses. A nack or a response timeout rolls the FIFO
// read pointer back to the last committed entry. After the rollback, responses
// are ignored for a fixed holdoff period, and then sending resumes.
// Optional statistics are enabled by defining BSG_FIFO_ROLLY_RETX_STATS_EN.
`timescale 1ns/1ps

module bsg_fifo_rolly_retx_ctrl #(
   parameter int width_p     = 8,
   parameter int lg_window_p = 2,
   parameter int timeout_p   = 16,
   parameter int holdoff_p   = 4
) (
   input  logic               clk_i,
   input  logic               reset_n_i,

   input  logic [width_p-1:0] fifo_data_i,
   input  logic               fifo_v_i,
   output logic               fifo_yumi_o,
   output logic               fifo_incr_o,
   output logic               fifo_rollback_o,
   output logic               fifo_ack_o,

   output logic [width_p-1:0] link_data_o,
   output logic               link_v_o,
   input  logic               link_ready_i,

   input  logic               resp_v_i,
   input  logic               resp_ack_i,
   input  logic               resp_all_i,

   output logic [15:0]        retx_count_o,
   output logic               spurious_o
);

   localparam int Win = 1 << lg_window_p;
   localparam int OW  = lg_window_p + 1;
   localparam int TW  = $clog2(timeout_p);
   localparam int HW  = (holdoff_p > 1) ? $clog2(holdoff_p) : 1;

   typedef enum logic [1:0] {
      SEND     = 2'd0,
      ROLLBACK = 2'd1,
      HOLDOFF  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [OW-1:0]   out_q, out_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [HW-1:0]   hold_q, hold_d;

   logic in_send, racc, timeout_hit, retx_evt;
   logic link_v, send, rel_one, rel_all, spur_evt;

   // Response acceptance, retransmit trigger and link handshake decode
   always_comb begin
      in_send     = (state_q == SEND);
      racc        = in_send & resp_v_i & (out_q != '0);
      spur_evt    = in_send & resp_v_i & (out_q == '0);
      timeout_hit = in_send & ~racc & (timer_q == TW'(timeout_p - 1));
      retx_evt    = (racc & ~resp_ack_i) | timeout_hit;
      link_v      = fifo_v_i & in_send & (out_q < OW'(Win)) & ~retx_evt;
      send        = link_v & link_ready_i;
      rel_one     = racc & resp_ack_i & ~resp_all_i;
      rel_all     = racc & resp_ack_i & resp_all_i;
   end

   // Outputs are forced low while reset is held, whatever the state
   always_comb begin
      link_data_o     = fifo_data_i;
      link_v_o        = reset_n_i & link_v;
      fifo_yumi_o     = reset_n_i & send;
      fifo_incr_o     = reset_n_i & rel_one;
      fifo_ack_o      = reset_n_i & rel_all;
      fifo_rollback_o = reset_n_i & (state_q == ROLLBACK);
   end

   // Next-state logic for the FSM, outstanding counter, timer and holdoff
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      timer_d = timer_q;
      hold_d  = hold_q;
      unique case (state_q)
         SEND: begin
            if (retx_evt) begin
               state_d = ROLLBACK;
               out_d   = '0;
               timer_d = '0;
            end else begin
               // A cumulative ack releases everything that was outstanding
               // before this cycle, so only this cycle's send remains.
               if (rel_all) out_d = OW'(send);
               else         out_d = out_q + OW'(send) - OW'(rel_one);
               if (racc || (out_q == '0)) timer_d = '0;
               else                       timer_d = timer_q + TW'(1);
            end
         end
         ROLLBACK: begin
            state_d = HOLDOFF;
            hold_d  = '0;
         end
         HOLDOFF: begin
            if (hold_q == HW'(holdoff_p - 1)) begin
               state_d = SEND;
               hold_d  = '0;
            end else begin
               hold_d  = hold_q + HW'(1);
            end
         end
         default: begin
            state_d = SEND;
            out_d   = '0;
            timer_d = '0;
            hold_d  = '0;
         end
      endcase
   end

   // Control state registers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= SEND;
         out_q   <= '0;
         timer_q <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         timer_q <= timer_d;
         hold_q  <= hold_d;
      end
   end

`ifdef BSG_FIFO_ROLLY_RETX_STATS_EN
   logic [15:0] retx_cnt_q;
   logic        spur_q;

   // Saturating rollback counter and sticky spurious-response flag
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         retx_cnt_q <= '0;
         spur_q     <= 1'b0;
      end else begin
         if (retx_evt && (retx_cnt_q != '1)) retx_cnt_q <= retx_cnt_q + 16'd1;
         if (spur_evt) spur_q <= 1'b1;
      end
   end

   assign retx_count_o = retx_cnt_q;
   assign spurious_o   = spur_q;
`else
   logic unused_spur;
   assign unused_spur  = spur_evt;
   assign retx_count_o = '0;
   assign spurious_o   = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_fifo_rolly_retx_ctrl.sv
// Directed bench for bsg_fifo_rolly_retx_ctrl (width 8, window 4, timeout 8,
// holdoff 4). A small rolly-FIFO model supplies the read side.
`timescale 1ns/1ps

module tb_bsg_fifo_rolly_retx_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n_i;
   logic [7:0]  fifo_data_i;
   logic        fifo_v_i;
   logic        fifo_yumi_o, fifo_incr_o, fifo_rollback_o, fifo_ack_o;
   logic [7:0]  link_data_o;
   logic        link_v_o;
   logic        link_ready_i;
   logic        resp_v_i, resp_ack_i, resp_all_i;
   logic [15:0] retx_count_o;
   logic        spurious_o;

   int checks = 0;
   int errors = 0;

`ifdef BSG_FIFO_ROLLY_RETX_STATS_EN
   localparam logic [15:0] EXP_RETX1 = 16'd1;
   localparam logic        EXP_SPUR  = 1'b1;
`else
   localparam logic [15:0] EXP_RETX1 = 16'd0;
   localparam logic        EXP_SPUR  = 1'b0;
`endif

   bsg_fifo_rolly_retx_ctrl #(
      .width_p    (8),
      .lg_window_p(2),
      .timeout_p  (8),
      .holdoff_p  (4)
   ) dut (
      .clk_i          (clk),
      .reset_n_i      (reset_n_i),
      .fifo_data_i    (fifo_data_i),
      .fifo_v_i       (fifo_v_i),
      .fifo_yumi_o    (fifo_yumi_o),
      .fifo_incr_o    (fifo_incr_o),
      .fifo_rollback_o(fifo_rollback_o),
      .fifo_ack_o     (fifo_ack_o),
      .link_data_o    (link_data_o),
      .link_v_o       (link_v_o),
      .link_ready_i   (link_ready_i),
      .resp_v_i       (resp_v_i),
      .resp_ack_i     (resp_ack_i),
      .resp_all_i     (resp_all_i),
      .retx_count_o   (retx_count_o),
      .spurious_o     (spurious_o)
   );

   // Rolly FIFO model: speculative read pointer plus commit pointer
   logic [7:0] mem [0:7];
   int         wr_cnt  = 0;
   int         rd_ptr  = 0;
   int         cmt_ptr = 0;
   logic       fifo_clear;

   assign fifo_v_i    = (rd_ptr < wr_cnt);
   assign fifo_data_i = mem[rd_ptr[2:0]];

   always @(posedge clk) begin
      if (fifo_clear) begin
         rd_ptr  <= 0;
         cmt_ptr <= 0;
      end else begin
         if (fifo_rollback_o)  rd_ptr <= cmt_ptr;
         else if (fifo_yumi_o) rd_ptr <= rd_ptr + 1;
         if (fifo_incr_o)      cmt_ptr <= cmt_ptr + 1;
         else if (fifo_ack_o)  cmt_ptr <= rd_ptr;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic load_fifo(input logic [7:0] base, input int n);
      for (int i = 0; i < 8; i++) mem[i] = base + 8'(i);
      wr_cnt = n;
   endtask

   // Reset with a fresh FIFO; returns at cycle 0 just after reset release
   task automatic do_reset(input logic [7:0] base, input int n);
      reset_n_i = 1'b0; fifo_clear = 1'b1; link_ready_i = 1'b1;
      resp_v_i = 1'b0; resp_ack_i = 1'b0; resp_all_i = 1'b0;
      load_fifo(base, n);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n_i = 1'b1; fifo_clear = 1'b0;
   endtask

   task automatic test_reset();
      reset_n_i = 1'b0; fifo_clear = 1'b1; link_ready_i = 1'b1;
      resp_v_i = 1'b0; resp_ack_i = 1'b0; resp_all_i = 1'b0;
      load_fifo(8'h11, 5);
      next_cycle();
      checks++; if (link_v_o !== 1'b0) begin errors++; $display("FAIL reset_link_v: got %b expected 0", link_v_o); end
      checks++; if (fifo_yumi_o !== 1'b0) begin errors++; $display("FAIL reset_yumi: got %b expected 0", fifo_yumi_o); end
      checks++; if ({fifo_incr_o, fifo_ack_o, fifo_rollback_o} !== 3'b000) begin errors++; $display("FAIL reset_ctl: got %b expected 000", {fifo_incr_o, fifo_ack_o, fifo_rollback_o}); end
      checks++; if (retx_count_o !== 16'd0) begin errors++; $display("FAIL reset_retx: got %0d expected 0", retx_count_o); end
      checks++; if (spurious_o !== 1'b0) begin errors++; $display("FAIL reset_spur: got %b expected 0", spurious_o); end
      reset_n_i = 1'b1; fifo_clear = 1'b0;
   endtask

   // Fill the window back to back, then stall at four outstanding
   task automatic test_send_window();
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (link_v_o !== 1'b1 || link_data_o !== 8'h11 + 8'(i) || fifo_yumi_o !== 1'b1) begin
            errors++; $display("FAIL window_send%0d: got v=%b d=%h y=%b expected v=1 d=%h y=1", i, link_v_o, link_data_o, fifo_yumi_o, 8'h11 + 8'(i));
         end
         next_cycle();
      end
      #1;
      checks++; if (link_v_o !== 1'b0) begin errors++; $display("FAIL window_full: got %b expected 0", link_v_o); end
   endtask

   // Acks stream in; one slot frees, 0x15 goes out while another ack lands
   task automatic test_ack_stream();
      resp_v_i = 1'b1; resp_ack_i = 1'b1; resp_all_i = 1'b0;
      #1;
      checks++; if (fifo_incr_o !== 1'b1 || link_v_o !== 1'b0) begin errors++; $display("FAIL ack_c4: got incr=%b v=%b expected incr=1 v=0", fifo_incr_o, link_v_o); end
      next_cycle();
      checks++; if (link_v_o !== 1'b1 || link_data_o !== 8'h15 || fifo_incr_o !== 1'b1) begin errors++; $display("FAIL ack_c5: got v=%b d=%h incr=%b expected v=1 d=15 incr=1", link_v_o, link_data_o, fifo_incr_o); end
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         checks++; if (fifo_incr_o !== 1'b1 || link_v_o !== 1'b0) begin errors++; $display("FAIL ack_drain%0d: got incr=%b v=%b expected incr=1 v=0", i, fifo_incr_o, link_v_o); end
      end
      next_cycle();
      checks++; if (fifo_incr_o !== 1'b0 || fifo_ack_o !== 1'b0) begin errors++; $display("FAIL ack_empty: got incr=%b ack=%b expected 0 0", fifo_incr_o, fifo_ack_o); end
      next_cycle();
      resp_v_i = 1'b0;
      #1;
      checks++; if (spurious_o !== EXP_SPUR) begin errors++; $display("FAIL ack_spur: got %b expected %b", spurious_o, EXP_SPUR); end
      checks++; if (fifo_rollback_o !== 1'b0) begin errors++; $display("FAIL ack_norb: got %b expected 0", fifo_rollback_o); end
   endtask

   // Nack on the second response: rollback, holdoff, resend from entry 2
   task automatic test_nack();
      do_reset(8'h21, 5);
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (link_v_o !== 1'b1 || link_data_o !== 8'h21 + 8'(i)) begin errors++; $display("FAIL nack_send%0d: got v=%b d=%h expected v=1 d=%h", i, link_v_o, link_data_o, 8'h21 + 8'(i)); end
         next_cycle();
      end
      resp_v_i = 1'b1; resp_ack_i = 1'b1;
      #1;
      checks++; if (fifo_incr_o !== 1'b1) begin errors++; $display("FAIL nack_first_ack: got %b expected 1", fifo_incr_o); end
      next_cycle();
      resp_ack_i = 1'b0;
      #1;
      checks++; if (link_v_o !== 1'b0 || fifo_incr_o !== 1'b0 || fifo_ack_o !== 1'b0 || fifo_rollback_o !== 1'b0) begin
         errors++; $display("FAIL nack_evt: got v=%b incr=%b ack=%b rb=%b expected 0 0 0 0", link_v_o, fifo_incr_o, fifo_ack_o, fifo_rollback_o);
      end
      next_cycle();
      resp_v_i = 1'b0;
      #1;
      checks++; if (fifo_rollback_o !== 1'b1 || link_v_o !== 1'b0 || fifo_yumi_o !== 1'b0) begin errors++; $display("FAIL nack_rollback: got rb=%b v=%b y=%b expected 1 0 0", fifo_rollback_o, link_v_o, fifo_yumi_o); end
      checks++; if (retx_count_o !== EXP_RETX1) begin errors++; $display("FAIL nack_retx: got %0d expected %0d", retx_count_o, EXP_RETX1); end
      next_cycle();
      for (int i = 0; i < 4; i++) begin
         resp_v_i = 1'b1; resp_ack_i = 1'b1;
         #1;
         checks++; if (link_v_o !== 1'b0 || fifo_incr_o !== 1'b0 || fifo_rollback_o !== 1'b0) begin errors++; $display("FAIL nack_holdoff%0d: got v=%b incr=%b rb=%b expected 0 0 0", i, link_v_o, fifo_incr_o, fifo_rollback_o); end
         next_cycle();
      end
      resp_v_i = 1'b0; resp_ack_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (link_v_o !== 1'b1 || link_data_o !== 8'h22 + 8'(i)) begin errors++; $display("FAIL nack_resend%0d: got v=%b d=%h expected v=1 d=%h", i, link_v_o, link_data_o, 8'h22 + 8'(i)); end
         next_cycle();
      end
      #1;
      checks++; if (spurious_o !== 1'b0) begin errors++; $display("FAIL nack_nospur: got %b expected 0", spurious_o); end
   endtask

   // Single entry with no response: rollback after the timeout expires
   task automatic test_timeout();
      do_reset(8'h31, 1);
      #1;
      checks++; if (link_v_o !== 1'b1 || link_data_o !== 8'h31) begin errors++; $display("FAIL to_send: got v=%b d=%h expected v=1 d=31", link_v_o, link_data_o); end
      next_cycle();
      for (int k = 1; k <= 8; k++) begin
         #1;
         checks++; if (fifo_rollback_o !== 1'b0) begin errors++; $display("FAIL to_wait%0d: got rb=%b expected 0", k, fifo_rollback_o); end
         next_cycle();
      end
      #1;
      checks++; if (fifo_rollback_o !== 1'b1) begin errors++; $display("FAIL to_rollback: got %b expected 1", fifo_rollback_o); end
      checks++; if (retx_count_o !== EXP_RETX1) begin errors++; $display("FAIL to_retx: got %0d expected %0d", retx_count_o, EXP_RETX1); end
   endtask

   // Cumulative ack clears all three outstanding; a further response is spurious
   task automatic test_cumulative();
      do_reset(8'h41, 3);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (link_v_o !== 1'b1 || link_data_o !== 8'h41 + 8'(i)) begin errors++; $display("FAIL cum_send%0d: got v=%b d=%h expected v=1 d=%h", i, link_v_o, link_data_o, 8'h41 + 8'(i)); end
         next_cycle();
      end
      resp_v_i = 1'b1; resp_ack_i = 1'b1; resp_all_i = 1'b1;
      #1;
      checks++; if (fifo_ack_o !== 1'b1 || fifo_incr_o !== 1'b0) begin errors++; $display("FAIL cum_ack: got ack=%b incr=%b expected 1 0", fifo_ack_o, fifo_incr_o); end
      next_cycle();
      resp_v_i = 1'b0; resp_all_i = 1'b0;
      #1;
      checks++; if (fifo_ack_o !== 1'b0 || spurious_o !== 1'b0) begin errors++; $display("FAIL cum_after: got ack=%b spur=%b expected 0 0", fifo_ack_o, spurious_o); end
      next_cycle();
      resp_v_i = 1'b1;
      #1;
      checks++; if (fifo_incr_o !== 1'b0) begin errors++; $display("FAIL cum_spur_incr: got %b expected 0", fifo_incr_o); end
      next_cycle();
      resp_v_i = 1'b0;
      #1;
      checks++; if (spurious_o !== EXP_SPUR) begin errors++; $display("FAIL cum_spur: got %b expected %b", spurious_o, EXP_SPUR); end
   endtask

   // Reset asserted in the middle of holdoff, then sending resumes
   task automatic test_reset_holdoff();
      do_reset(8'h51, 5);
      #1;
      checks++; if (link_v_o !== 1'b1 || link_data_o !== 8'h51) begin errors++; $display("FAIL rh_send: got v=%b d=%h expected v=1 d=51", link_v_o, link_data_o); end
      next_cycle();
      resp_v_i = 1'b1; resp_ack_i = 1'b0;
      #1;
      checks++; if (link_v_o !== 1'b0) begin errors++; $display("FAIL rh_nack_v: got %b expected 0", link_v_o); end
      next_cycle();
      resp_v_i = 1'b0;
      #1;
      checks++; if (fifo_rollback_o !== 1'b1) begin errors++; $display("FAIL rh_rollback: got %b expected 1", fifo_rollback_o); end
      next_cycle();
      #1;
      checks++; if (link_v_o !== 1'b0 || retx_count_o !== EXP_RETX1) begin errors++; $display("FAIL rh_holdoff: got v=%b retx=%0d expected v=0 retx=%0d", link_v_o, retx_count_o, EXP_RETX1); end
      reset_n_i = 1'b0;
      #1;
      checks++; if (link_v_o !== 1'b0 || fifo_yumi_o !== 1'b0 || fifo_rollback_o !== 1'b0 || retx_count_o !== 16'd0) begin
         errors++; $display("FAIL rh_in_reset: got v=%b y=%b rb=%b retx=%0d expected 0 0 0 0", link_v_o, fifo_yumi_o, fifo_rollback_o, retx_count_o);
      end
      next_cycle();
      checks++; if (link_v_o !== 1'b0) begin errors++; $display("FAIL rh_in_reset2: got %b expected 0", link_v_o); end
      reset_n_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (link_v_o !== 1'b1 || link_data_o !== 8'h51 + 8'(i) || fifo_yumi_o !== 1'b1) begin
            errors++; $display("FAIL rh_resume%0d: got v=%b d=%h y=%b expected v=1 d=%h y=1", i, link_v_o, link_data_o, fifo_yumi_o, 8'h51 + 8'(i));
         end
         next_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_send_window();
      test_ack_stream();
      test_nack();
      test_timeout();
      test_cumulative();
      test_reset_holdoff();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
